mem_initiator: RTL and testbench

- Initiator (master) side of the native valid/ready memory port used by the SRAM test memory.
- Accepts read/write commands on a valid/ready command channel and buffers them in a small FIFO.
- Issues the commands one at a time as memory transactions and returns each result on a valid/ready response channel.
- Used as a bench traffic source and as the memory-port front end for non-CPU agents, e.g. loaders and console writers.

---
 rtl/mem_initiator_pkg.sv | 15 +
 rtl/mem_cmd_fifo.sv | 48 ++++
 rtl/mem_initiator.sv | 158 +++++++++++++++
 tb/tb_mem_initiator.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_initiator_pkg.sv
// Shared types for the native memory-port initiator: FSM states, buffered command
// record and the strobe encoding that marks a read.
package mem_initiator_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_cmd_t;

    localparam logic [3:0] WSTRB_READ = 4'b0000;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous command FIFO for mem_initiator; DEPTH must be a power of two so the
// pointers wrap by natural overflow.
module mem_cmd_fifo
    import mem_initiator_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  mem_cmd_t      push_data,
    input  logic          pop,
    output mem_cmd_t      pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    mem_cmd_t      entries [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    // A push is refused when full even if a pop frees a slot in the same cycle.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = entries[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) entries[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mem_initiator.sv
// Native valid/ready memory-port initiator: buffers commands and issues them one at a time.
// Optional request abort after TIMEOUT cycles is enabled by defining MEM_INITIATOR_TIMEOUT_EN.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_write,
    output logic        rsp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int CW = $clog2(CMD_DEPTH) + 1;

    generate
        if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_param
            $error("mem_initiator: CMD_DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
        end
    endgenerate

    state_t        state, state_n;
    mem_cmd_t      head, cmd_in;
    logic          fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0] fifo_count;
    logic          mem_valid_n, rsp_valid_n, rsp_write_n;
    logic [31:0]   mem_addr_n, mem_wdata_n, rsp_rdata_n;
    logic [3:0]    mem_wstrb_n;

    assign cmd_in    = '{addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};
    assign cmd_ready = !reset && !fifo_full;
    assign busy      = (fifo_count != '0) || (state != IDLE);

    mem_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (cmd_valid && cmd_ready),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef MEM_INITIATOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] tmo_cnt;
    logic          rsp_err_q, rsp_err_n;

    // Counter is zero whenever outside REQ, so it starts clean on every entry.
    always_ff @(posedge clock) begin
        if (reset || state != REQ) tmo_cnt <= '0;
        else if (!mem_ready)       tmo_cnt <= tmo_cnt + TW'(1);
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        fifo_pop    = 1'b0;
        mem_valid_n = mem_valid;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_wstrb_n = mem_wstrb;
        rsp_valid_n = rsp_valid;
        rsp_rdata_n = rsp_rdata;
        rsp_write_n = rsp_write;
`ifdef MEM_INITIATOR_TIMEOUT_EN
        rsp_err_n   = rsp_err_q;
`endif
        case (state)
            IDLE: if (!fifo_empty) begin
                fifo_pop    = 1'b1;
                mem_valid_n = 1'b1;
                mem_addr_n  = head.addr;
                mem_wdata_n = head.wdata;
                mem_wstrb_n = head.wstrb;
                state_n     = REQ;
            end
            REQ: begin
                // A ready on the expiry cycle still completes normally.
                if (mem_ready) begin
                    mem_valid_n = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_write_n = (mem_wstrb != WSTRB_READ);
                    rsp_rdata_n = (mem_wstrb == WSTRB_READ) ? mem_rdata : 32'h0;
                    state_n     = RESP;
                end
`ifdef MEM_INITIATOR_TIMEOUT_EN
                else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    mem_valid_n = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_write_n = (mem_wstrb != WSTRB_READ);
                    rsp_rdata_n = 32'h0;
                    rsp_err_n   = 1'b1;
                    state_n     = RESP;
                end
`endif
            end
            RESP: if (rsp_ready) begin
                rsp_valid_n = 1'b0;
`ifdef MEM_INITIATOR_TIMEOUT_EN
                rsp_err_n   = 1'b0;
`endif
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_write <= 1'b0;
`ifdef MEM_INITIATOR_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            mem_valid <= mem_valid_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_wstrb <= mem_wstrb_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_write <= rsp_write_n;
`ifdef MEM_INITIATOR_TIMEOUT_EN
            rsp_err_q <= rsp_err_n;
`endif
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Randomized bench for mem_initiator: an SRAM-like responder plus a transaction-level
// model (in-order queues over a word memory) that predicts every request and response.
module tb_mem_initiator;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_write, rsp_err;
    logic        mem_valid, mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_wstrb;
    logic        busy;

    mem_initiator dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_write(rsp_write), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } req_t;
    typedef struct { logic [31:0] rdata; logic write; } rsp_t;

    logic [31:0] model_mem [int unsigned];
    logic [31:0] resp_mem  [int unsigned];
    req_t req_q[$];
    rsp_t rsp_q[$];

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        model_mem[a >> 2] = d;
        resp_mem[a >> 2]  = d;
    endtask

    // Reference: each accepted command is executed in order against the model memory.
    task automatic model_accept(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] old;
        req_t r;
        rsp_t p;
        old = model_mem.exists(a >> 2) ? model_mem[a >> 2] : 32'h0;
        r.a = a; r.d = d; r.s = s;
        req_q.push_back(r);
        if (s == 4'b0000) begin
            p.rdata = old; p.write = 1'b0;
        end else begin
            model_mem[a >> 2] = merge(old, d, s);
            p.rdata = 32'h0; p.write = 1'b1;
        end
        rsp_q.push_back(p);
    endtask

    // Responder: random ready delay per request, stall holds ready low.
    logic stall = 1'b0, started = 1'b0, tests_passed = 1'b0;
    int   max_dly = 0, dly = 0;
    always @(posedge clock) begin
        logic [31:0] old;
        #1;
        if (mem_ready || !mem_valid || reset) begin
            mem_ready = 1'b0;
            started   = 1'b0;
        end else if (!stall) begin
            if (!started) begin
                started = 1'b1;
                dly = $urandom_range(0, max_dly);
            end
            if (dly == 0) begin
                mem_ready = 1'b1;
                old = resp_mem.exists(mem_addr >> 2) ? resp_mem[mem_addr >> 2] : 32'h0;
                if (mem_wstrb == 4'b0000) mem_rdata = old;
                else begin
                    resp_mem[mem_addr >> 2] = merge(old, mem_wdata, mem_wstrb);
                    mem_rdata = $urandom;
                    if (mem_addr == 32'h1000_0000) $display("%c", mem_wdata[7:0]);
                    if (mem_addr == 32'h2000_0000 && mem_wdata == 32'd123456789) tests_passed = 1'b1;
                end
            end else dly--;
        end
        if (!mem_ready) mem_rdata = $urandom;
    end

    logic rsp_rand = 1'b0, rsp_force = 1'b0;
    always @(posedge clock) begin
        #1;
        rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : rsp_force;
    end

    // Monitor on the falling edge: everything seen here is what the next rising edge acts on.
    logic        mv_hold = 1'b0, rv_hold = 1'b0, seen_req = 1'b0;
    int          gap = 0, n_rsp = 0;
    logic [31:0] h_addr, h_wdata, h_rdata, last_rdata = '0;
    logic [3:0]  h_wstrb;
    logic        h_write, last_write = 1'b0;
    req_t        er;
    rsp_t        ep;
    always @(negedge clock) begin
        if (reset) begin
            mv_hold = 1'b0; rv_hold = 1'b0; seen_req = 1'b0; gap = 0;
        end else begin
            if (cmd_valid && cmd_ready) model_accept(cmd_addr, cmd_wdata, cmd_wstrb);
            if (mem_valid) begin
                if (mv_hold) begin
                    chk("mem_addr_stable", mem_addr, h_addr);
                    chk("mem_wdata_stable", mem_wdata, h_wdata);
                    chk("mem_wstrb_stable", 32'(mem_wstrb), 32'(h_wstrb));
                end else if (seen_req) chk("mem_gap_ge2", 32'(gap >= 2), 32'd1);
                seen_req = 1'b1; gap = 0;
                if (mem_ready) begin
                    if (req_q.size() == 0) chk("mem_unexpected", 32'd1, 32'd0);
                    else begin
                        er = req_q.pop_front();
                        chk("mem_addr", mem_addr, er.a);
                        chk("mem_wdata", mem_wdata, er.d);
                        chk("mem_wstrb", 32'(mem_wstrb), 32'(er.s));
                    end
                end
                mv_hold = !mem_ready;
                h_addr = mem_addr; h_wdata = mem_wdata; h_wstrb = mem_wstrb;
            end else begin
                gap++; mv_hold = 1'b0;
            end
            if (rsp_valid) begin
                if (rv_hold) begin
                    chk("rsp_rdata_stable", rsp_rdata, h_rdata);
                    chk("rsp_write_stable", 32'(rsp_write), 32'(h_write));
                end
                if (rsp_ready) begin
                    if (rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                    else begin
                        ep = rsp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, ep.rdata);
                        chk("rsp_write", 32'(rsp_write), 32'(ep.write));
                        chk("rsp_err", 32'(rsp_err), 32'd0);
                    end
                    last_rdata = rsp_rdata; last_write = rsp_write; n_rsp++;
                end
                rv_hold = !rsp_ready;
                h_rdata = rsp_rdata; h_write = rsp_write;
            end else rv_hold = 1'b0;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int   t;
        logic acc;
        t = 0; acc = 1'b0;
        cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        while (!acc && t < 1000) begin
            @(negedge clock); acc = cmd_ready;
            @(posedge clock); #1; t++;
        end
        cmd_valid = 1'b0;
        if (!acc) chk("send_bound", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || rsp_valid || rsp_q.size() != 0) && t < 5000) begin
            @(posedge clock); #1; t++;
        end
        chk("idle_bound", 32'(t >= 5000), 32'd0);
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    initial begin
        int n0, t;
        logic [3:0] s;
        // Reset state
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_write", 32'(rsp_write), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();

        // Read with latency check against a one-cycle responder
        preload(32'h100, 32'hDEADBEEF);
        cmd_addr = 32'h100; cmd_wdata = 32'h0; cmd_wstrb = 4'b0000; cmd_valid = 1'b1;
        @(negedge clock);
        chk("lat_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("lat_n_mem_valid", 32'(mem_valid), 32'd0);
        chk("lat_n_busy", 32'(busy), 32'd1);
        tick();
        chk("lat_n1_mem_valid", 32'(mem_valid), 32'd1);
        chk("lat_n1_mem_addr", mem_addr, 32'h100);
        chk("lat_n1_mem_wstrb", 32'(mem_wstrb), 32'd0);
        tick();
        chk("lat_n2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("lat_n2_mem_valid", 32'(mem_valid), 32'd0);
        chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("rd_write", 32'(rsp_write), 32'd0);
        rsp_force = 1'b1;
        wait_idle();

        // Partial write then read-back over a zero preset
        max_dly = 2;
        preload(32'h104, 32'h0);
        send(32'h104, 32'h11223344, 4'b0101);
        send(32'h104, 32'h0, 4'b0000);
        wait_idle();
        chk("pw_rdata", last_rdata, 32'h00220044);

        // Backpressure: first command parks in RESP, the next four fill the FIFO
        max_dly = 0;
        rsp_force = 1'b0;
        tick();
        n0 = n_rsp;
        for (int i = 0; i < 5; i++) send(32'h180 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
        @(negedge clock);
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_mem_valid", 32'(mem_valid), 32'd0);
        tick();
        rsp_force = 1'b1;
        wait_idle();
        chk("bp_drained", 32'(n_rsp - n0), 32'd5);

        // Console character and pass flag
        send(32'h1000_0000, 32'h41, 4'b0001);
        send(32'h2000_0000, 32'd123456789, 4'hF);
        wait_idle();
        chk("tests_passed", 32'(tests_passed), 32'd1);
        chk("console_write", 32'(last_write), 32'd1);

        // Reset while the request is stuck in REQ
        preload(32'h300, 32'hCAFEF00D);
        stall = 1'b1;
        send(32'h300, 32'h0, 4'b0000);
        t = 0;
        while (!mem_valid && t < 20) begin tick(); t++; end
        chk("rst_req_reached", 32'(mem_valid), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("rst_mid_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        req_q.delete();
        rsp_q.delete();
        stall = 1'b0;
        @(negedge clock);
        chk("rst_mid_cmd_ready_after", 32'(cmd_ready), 32'd1);
        tick();
        send(32'h300, 32'h0, 4'b0000);
        wait_idle();
        chk("rst_next_rdata", last_rdata, 32'hCAFEF00D);

        // Random traffic over a small address window
        rsp_rand = 1'b1;
        max_dly = 3;
        for (int i = 0; i < 150; i++) begin
            s = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            send(32'h200 + 32'(4 * $urandom_range(0, 7)), $urandom, s);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle();
        chk("queues_empty", 32'(req_q.size() + rsp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
